// File: rtl/dmem_lsu.sv
// RV32 data-memory load/store unit: aligns, extends and lane-positions accesses to a 1-cycle RAM.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two RAM cycles instead of faulting.
module dmem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        dmem_en,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_d,
  output logic [3:0]  dmem_we,
  input  logic [31:0] dmem_q
);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // the response is an unconditional single-cycle resp_valid pulse (no backpressure).
  typedef enum logic [1:0] {IDLE, WAIT1, ISSUE2, WAIT2} state_t;

  state_t      state_q, state_d;
  logic        we_q, fault_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, lo_q;
  logic        resp_valid_q, resp_fault_q;
  logic [31:0] resp_rdata_q;

  logic        req_bad, req_cross;
  logic [2:0]  src_f3;
  logic [1:0]  src_off;
  logic [31:0] src_wdata;
  logic [7:0]  wide_mask;
  logic [63:0] wide_data;
  logic [63:0] pair;
  logic [31:0] aligned;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'b0, d[7:0]};
      3'b101:  return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

`ifdef MISALIGNED_SPLIT_EN
  function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off == 2'b11) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

  assign req_bad   = illegal_f3(req_we, req_funct3);
  assign req_cross = crosses_word(req_funct3, req_addr[1:0]);
`else
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

  assign req_bad   = illegal_f3(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign req_cross = 1'b0;
`endif

  // Lane positioning uses the live request in IDLE and the captured one for the second half.
  always_comb begin
    src_f3    = (state_q == IDLE) ? req_funct3    : funct3_q;
    src_off   = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    src_wdata = (state_q == IDLE) ? req_wdata     : wdata_q;
    wide_mask = {4'b0000, size_mask(src_f3[1:0])} << src_off;
    wide_data = {32'b0, src_wdata} << {src_off, 3'b000};
  end

  // Low word sits in the lower half of the pair; a single access reads its bytes from dmem_q alone.
  always_comb begin
    pair    = {dmem_q, (state_q == WAIT2) ? lo_q : dmem_q};
    aligned = 32'(pair >> {addr_q[1:0], 3'b000});
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    dmem_en   = 1'b0;
    dmem_addr = 32'b0;
    dmem_d    = 32'b0;
    dmem_we   = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad) begin
            state_d = WAIT1;
          end else begin
            dmem_en   = 1'b1;
            dmem_addr = {2'b00, req_addr[31:2]};
            dmem_we   = req_we ? wide_mask[3:0] : 4'b0000;
            dmem_d    = wide_data[31:0];
            state_d   = req_cross ? ISSUE2 : WAIT1;
          end
        end
      end
      WAIT1: state_d = IDLE;
      ISSUE2: begin
        dmem_en   = 1'b1;
        dmem_addr = {2'b00, addr_q[31:2] + 30'd1};
        dmem_we   = we_q ? wide_mask[7:4] : 4'b0000;
        dmem_d    = wide_data[63:32];
        state_d   = WAIT2;
      end
      WAIT2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d   = IDLE;
      req_ready = 1'b0;
      dmem_en   = 1'b0;
      dmem_addr = 32'b0;
      dmem_d    = 32'b0;
      dmem_we   = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      lo_q         <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            fault_q      <= req_bad;
            resp_valid_q <= req_bad;
            resp_fault_q <= req_bad;
          end
        end
        // A faulted request already responded; WAIT1 is then just its busy cycle.
        WAIT1: begin
          if (!fault_q) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'b0 : extend(funct3_q, aligned);
          end
        end
        ISSUE2: lo_q <= dmem_q;
        WAIT2: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= we_q ? 32'b0 : extend(funct3_q, aligned);
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table, hand-written timing sequences and a response scoreboard.
// Expected values for misaligned cases follow MISALIGNED_SPLIT_EN.
module tb_dmem_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        dmem_en;
  logic [31:0] dmem_addr, dmem_d, dmem_q;
  logic [3:0]  dmem_we;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_d(dmem_d),
    .dmem_we(dmem_we), .dmem_q(dmem_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // 64-word synchronous RAM model, read-before-write
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_q <= ram[dmem_addr[5:0]];
      for (int l = 0; l < 4; l++)
        if (dmem_we[l]) ram[dmem_addr[5:0]][l*8 +: 8] <= dmem_d[l*8 +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: {fault, rdata}
  logic [32:0] exp_q[$];

  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, e[32]});
        chk("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // driver: present a request and hold it until req_ready is seen (before the accept edge)
  int acc_cyc;
  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [32:0] exp);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    acc_cyc = cyc;
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] d;
    logic        fault;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic en, logic [3:0] dwe, logic [31:0] da, logic [31:0] d,
                              logic fault, logic [31:0] rd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.en = en; v.dwe = dwe;
    v.daddr = da; v.d = d; v.fault = fault; v.rdata = rd;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'b0;
    dmem_q = 32'b0;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h1;

    // reset: request presented while rst=1 must be ignored
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_dmem_en", {31'b0, dmem_en}, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_we", {28'b0, dmem_we}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    //        we    f3      addr          wdata         en    dwe     daddr         d             fault rdata
    vt.push_back(mk(1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 1'b1, 4'hF,   32'h4,        32'hDEADBEEF, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 3'b010, 32'h10,       32'h0,        1'b1, 4'h0,   32'h4,        32'h0,        1'b0, 32'hDEADBEEF));
    vt.push_back(mk(1'b1, 3'b000, 32'h13,       32'h00000080, 1'b1, 4'b1000,32'h4,        32'h80000000, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 3'b000, 32'h13,       32'h0,        1'b1, 4'h0,   32'h4,        32'h0,        1'b0, 32'hFFFFFF80));
    vt.push_back(mk(1'b0, 3'b100, 32'h13,       32'h0,        1'b1, 4'h0,   32'h4,        32'h0,        1'b0, 32'h00000080));
    vt.push_back(mk(1'b1, 3'b001, 32'h22,       32'h1234A55A, 1'b1, 4'hC,   32'h8,        32'hA55A0000, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 32'h22,       32'h0,        1'b1, 4'h0,   32'h8,        32'h0,        1'b0, 32'hFFFFA55A));
    vt.push_back(mk(1'b0, 3'b101, 32'h22,       32'h0,        1'b1, 4'h0,   32'h8,        32'h0,        1'b0, 32'h0000A55A));
    vt.push_back(mk(1'b0, 3'b010, 32'h20,       32'h0,        1'b1, 4'h0,   32'h8,        32'h0,        1'b0, 32'hA55A0000));
    vt.push_back(mk(1'b0, 3'b011, 32'h10,       32'h0,        1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
    vt.push_back(mk(1'b1, 3'b100, 32'h10,       32'h55,       1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
    vt.push_back(mk(1'b0, 3'b110, 32'h0,        32'h0,        1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
    vt.push_back(mk(1'b0, 3'b111, 32'h0,        32'h0,        1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
`ifdef MISALIGNED_SPLIT_EN
    vt.push_back(mk(1'b0, 3'b010, 32'h0E,       32'h0,        1'b1, 4'h0,   32'h3,        32'h0,        1'b0, 32'hBEEF0000));
    vt.push_back(mk(1'b0, 3'b001, 32'h11,       32'h0,        1'b1, 4'h0,   32'h4,        32'h0,        1'b0, 32'hFFFFADBE));
`else
    vt.push_back(mk(1'b0, 3'b010, 32'h0E,       32'h0,        1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
    vt.push_back(mk(1'b0, 3'b001, 32'h11,       32'h0,        1'b0, 4'h0,   32'h0,        32'h0,        1'b1, 32'h0));
`endif
    vt.push_back(mk(1'b1, 3'b000, 32'hFFFFFFFF, 32'h0000007F, 1'b1, 4'b1000,32'h3FFFFFFF, 32'h7F000000, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        1'b1, 4'h0,   32'h3FFFFFFF, 32'h0,        1'b0, 32'h0000007F));
    vt.push_back(mk(1'b1, 3'b000, 32'h01,       32'hFFFFFF12, 1'b1, 4'b0010,32'h0,        32'h00001200, 1'b0, 32'h0));
    vt.push_back(mk(1'b0, 3'b010, 32'h00,       32'h0,        1'b1, 4'h0,   32'h0,        32'h0,        1'b0, 32'h00001200));
    vt.push_back(mk(1'b0, 3'b100, 32'h01,       32'h0,        1'b1, 4'h0,   32'h0,        32'h0,        1'b0, 32'h00000012));

    @(negedge clk);
    foreach (vt[i]) begin
      vec_t v;
      logic [31:0] m;
      v = vt[i];
      present(v.we, v.f3, v.addr, v.wdata, {v.fault, v.rdata});
      chk($sformatf("v%0d_dmem_en", i), {31'b0, dmem_en}, {31'b0, v.en});
      chk($sformatf("v%0d_dmem_we", i), {28'b0, dmem_we}, {28'b0, v.dwe});
      chk($sformatf("v%0d_dmem_addr", i), dmem_addr, v.daddr);
      if (v.we && !v.fault) begin
        m = {{8{v.dwe[3]}}, {8{v.dwe[2]}}, {8{v.dwe[1]}}, {8{v.dwe[0]}}};
        chk($sformatf("v%0d_dmem_d", i), dmem_d & m, v.d & m);
      end
      @(negedge clk);
      req_valid = 1'b0;
      drain();
    end

    // load latency: resp_valid exactly 2 cycles after acceptance, ready only when IDLE
    present(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80ADBEEF});
    @(negedge clk); req_valid = 1'b0; #1;
    chk("lat_t1_valid", {31'b0, resp_valid}, 32'd0);
    chk("lat_t1_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk); #1;
    chk("lat_t2_valid", {31'b0, resp_valid}, 32'd1);
    chk("lat_t2_ready", {31'b0, req_ready}, 32'd1);
    drain();

    // illegal funct3: fault one cycle after acceptance, ready low only that cycle
    present(1'b0, 3'b011, 32'h10, 32'h0, {1'b1, 32'h0});
    @(negedge clk); req_valid = 1'b0; #1;
    chk("flt_t1_valid", {31'b0, resp_valid}, 32'd1);
    chk("flt_t1_fault", {31'b0, resp_fault}, 32'd1);
    chk("flt_t1_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk); #1;
    chk("flt_t2_ready", {31'b0, req_ready}, 32'd1);
    chk("flt_t2_valid", {31'b0, resp_valid}, 32'd0);
    drain();

    // reset while in WAIT1 discards the request
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; #1;
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
    chk("rstw_dmem_en", {31'b0, dmem_en}, 32'd0);
    chk("rstw_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk); #1;
    chk("rstw_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstw_dmem_en2", {31'b0, dmem_en}, 32'd0);
    rst = 1'b0; #1;
    chk("rstw_idle_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    present(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80ADBEEF});
    @(negedge clk); req_valid = 1'b0;
    drain();

    // back-to-back: req_valid held high, alternating stores and loads
    begin
      int prev;
      prev = 0;
      present(1'b1, 3'b010, 32'h30, 32'h11111111, {1'b0, 32'h0});           prev = acc_cyc; @(negedge clk);
      present(1'b0, 3'b010, 32'h30, 32'h0, {1'b0, 32'h11111111});
      chk("b2b_gap1", acc_cyc - prev, 32'd2); prev = acc_cyc; @(negedge clk);
      present(1'b1, 3'b010, 32'h34, 32'h22222222, {1'b0, 32'h0});
      chk("b2b_gap2", acc_cyc - prev, 32'd2); prev = acc_cyc; @(negedge clk);
      present(1'b0, 3'b010, 32'h34, 32'h0, {1'b0, 32'h22222222});
      chk("b2b_gap3", acc_cyc - prev, 32'd2); prev = acc_cyc; @(negedge clk);
      present(1'b1, 3'b000, 32'h30, 32'h00000033, {1'b0, 32'h0});
      chk("b2b_gap4", acc_cyc - prev, 32'd2); prev = acc_cyc; @(negedge clk);
      present(1'b0, 3'b010, 32'h30, 32'h0, {1'b0, 32'h11111133});
      chk("b2b_gap5", acc_cyc - prev, 32'd2); @(negedge clk);
      req_valid = 1'b0;
      drain();
    end

`ifdef MISALIGNED_SPLIT_EN
    // word-crossing load: accesses at word 3 then 4, response at T+3
    present(1'b0, 3'b010, 32'h0E, 32'h0, {1'b0, 32'hBEEF0000});
    chk("spl_addr_lo", dmem_addr, 32'h3);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("spl_en_hi", {31'b0, dmem_en}, 32'd1);
    chk("spl_addr_hi", dmem_addr, 32'h4);
    @(negedge clk); #1;
    chk("spl_t2_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk); #1;
    chk("spl_t3_valid", {31'b0, resp_valid}, 32'd1);
    drain();
    // crossing store wraps the word index to 0
    present(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, {1'b0, 32'h0});
    chk("wrap_we_lo", {28'b0, dmem_we}, 32'h8);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("wrap_addr_hi", dmem_addr, 32'h0);
    chk("wrap_we_hi", {28'b0, dmem_we}, 32'h1);
    drain();
    @(negedge clk);
    present(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, {1'b0, 32'h0000ABCD});
    @(negedge clk); req_valid = 1'b0;
    drain();
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
